// File: rtl/montgomery_seq_ctrl.sv
// montgomery_seq_ctrl: computes y = a*b mod m by running one shared
// Montgomery multiplier core four times:
//   S0: a  * R^2 -> AM    S1: b  * R^2 -> BM
//   S2: AM * BM  -> YM    S3: YM * 1   -> y
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   enable_p                  start pulse (accepted only when idle)
//   a, b, m, m_inv, r_red     operands, modulus, Montgomery constant, R^2 mod m
//   y                         result, updated only when S3 completes
//   done_irq_p, err_timeout_p completion / core-timeout pulses
//   busy                      sequence in progress
//   core_*                    handshake and operands of the shared core
module montgomery_seq_ctrl #(
  parameter int unsigned NBITS       = 2048,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_p,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  input  logic [NBITS-1:0] m,
  input  logic [NBITS-1:0] m_inv,
  input  logic [NBITS-1:0] r_red,
  output logic [NBITS-1:0] y,
  output logic             done_irq_p,
  output logic             err_timeout_p,
  output logic             busy,
  output logic             core_enable_p,
  output logic [NBITS-1:0] core_a,
  output logic [NBITS-1:0] core_b,
  output logic [NBITS-1:0] core_m,
  output logic [NBITS-1:0] core_m_inv,
  input  logic [NBITS-1:0] core_y,
  input  logic             core_done_p
);

  // Counter only needs to reach TIMEOUT_CYC-1; the timeout fires on that WAIT cycle.
  localparam int unsigned     CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NBITS-1:0]   b_q, b_d;
  logic [NBITS-1:0]   r_red_q, r_red_d;
  logic [NBITS-1:0]   am_q, am_d;
  logic [NBITS-1:0]   bm_q, bm_d;
  logic [NBITS-1:0]   ym_q, ym_d;
  logic [NBITS-1:0]   y_q, y_d;
  logic [NBITS-1:0]   core_a_q, core_a_d;
  logic [NBITS-1:0]   core_b_q, core_b_d;
  logic [NBITS-1:0]   core_m_q, core_m_d;
  logic [NBITS-1:0]   core_m_inv_q, core_m_inv_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               core_en_q, core_en_d;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      step_q       <= 2'd0;
      cnt_q        <= '0;
      b_q          <= '0;
      r_red_q      <= '0;
      am_q         <= '0;
      bm_q         <= '0;
      ym_q         <= '0;
      y_q          <= '0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      core_m_q     <= '0;
      core_m_inv_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      core_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      b_q          <= b_d;
      r_red_q      <= r_red_d;
      am_q         <= am_d;
      bm_q         <= bm_d;
      ym_q         <= ym_d;
      y_q          <= y_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      core_m_q     <= core_m_d;
      core_m_inv_q <= core_m_inv_d;
      done_q       <= done_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      core_en_q    <= core_en_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    b_d          = b_q;
    r_red_d      = r_red_q;
    am_d         = am_q;
    bm_d         = bm_q;
    ym_d         = ym_q;
    y_d          = y_q;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    core_m_d     = core_m_q;
    core_m_inv_d = core_m_inv_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_p) begin
          // core_a holds operand A for S0, so A needs no separate latch.
          core_a_d     = a;
          core_b_d     = r_red;
          b_d          = b;
          r_red_d      = r_red;
          core_m_d     = m;
          core_m_inv_d = m_inv;
          step_d       = 2'd0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done_p) begin
          // Operands for the next step are loaded here so they are stable in ISSUE.
          case (step_q)
            2'd0: begin
              am_d     = core_y;
              core_a_d = b_q;
              core_b_d = r_red_q;
            end
            2'd1: begin
              bm_d     = core_y;
              core_a_d = am_q;
              core_b_d = bm_d;
            end
            2'd2: begin
              ym_d     = core_y;
              core_a_d = ym_d;
              core_b_d = NBITS'(1);
            end
            default: begin
              y_d    = core_y;
              done_d = 1'b1;
            end
          endcase
          if (step_q != 2'd3) begin
            step_d  = step_q + 2'd1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = (state_d != S_IDLE);
    core_en_d = (state_d == S_ISSUE);
  end

  assign y             = y_q;
  assign done_irq_p    = done_q;
  assign err_timeout_p = err_q;
  assign busy          = busy_q;
  assign core_enable_p = core_en_q;
  assign core_a        = core_a_q;
  assign core_b        = core_b_q;
  assign core_m        = core_m_q;
  assign core_m_inv    = core_m_inv_q;

endmodule

// File: tb/tb_montgomery_seq_ctrl.sv
// Directed bench for montgomery_seq_ctrl: NBITS=8, m=13, R=256, r_red=3,
// behavioural core with programmable latency, TIMEOUT_CYC=32.
module tb_montgomery_seq_ctrl;

  localparam int unsigned NB   = 8;
  localparam int unsigned TO   = 32;
  localparam int          MOD  = 13;
  localparam int          RINV = 3;   // 256^-1 mod 13 (256 = 9 mod 13, 9*3 = 27 = 1)

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable_p = 1'b0;
  logic [NB-1:0] a = '0, b = '0;
  logic [NB-1:0] m = 8'd13, m_inv = 8'd59, r_red = 8'd3;
  logic [NB-1:0] y;
  logic          done_irq_p, err_timeout_p, busy, core_enable_p;
  logic [NB-1:0] core_a, core_b, core_m, core_m_inv;
  logic [NB-1:0] core_y = '0;
  logic          core_done_p;
  logic          model_done = 1'b0;
  logic          force_done = 1'b0;

  assign core_done_p = model_done | force_done;

  always #5 clk = ~clk;

  montgomery_seq_ctrl #(.NBITS(NB), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .enable_p(enable_p),
    .a(a), .b(b), .m(m), .m_inv(m_inv), .r_red(r_red),
    .y(y), .done_irq_p(done_irq_p), .err_timeout_p(err_timeout_p), .busy(busy),
    .core_enable_p(core_enable_p), .core_a(core_a), .core_b(core_b),
    .core_m(core_m), .core_m_inv(core_m_inv),
    .core_y(core_y), .core_done_p(core_done_p)
  );

  // Behavioural core: done pulse core_lat cycles after the core_enable_p cycle.
  int        core_lat  = 3;
  bit        core_hang = 1'b0;
  int        mcnt = 0;
  logic [7:0] mres = '0;
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (mcnt != 0) begin
      if (mcnt == 1) begin
        model_done <= 1'b1;
        core_y     <= mres;
      end
      mcnt <= mcnt - 1;
    end
    if (core_enable_p && !core_hang) begin
      mcnt <= core_lat - 1;
      mres <= 8'((int'(core_a) * int'(core_b) * RINV) % MOD);
    end
  end

  // Cycle counter and pulse monitors.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cen = 0, n_done = 0, n_err = 0, n_both = 0;
  int done_cyc = 0, err_cyc = 0;
  logic [NB-1:0] last_core_b = '0;
  always @(negedge clk) begin
    if (core_enable_p) begin
      n_cen++;
      last_core_b = core_b;
    end
    if (done_irq_p) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err_timeout_p) begin
      n_err++;
      err_cyc = cyc;
    end
    if (done_irq_p && err_timeout_p) n_both++;
  end

  int n_cmp = 0, n_bad = 0;
  int en_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, want);
    end
  endtask

  // Step to just after the next falling edge (monitors have already updated).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input logic [NB-1:0] av, input logic [NB-1:0] bv);
    a        = av;
    b        = bv;
    enable_p = 1'b1;
    en_cyc   = cyc;
    tick();
    enable_p = 1'b0;
  endtask

  task automatic wait_evt(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done_irq_p || err_timeout_p) got = 1'b1;
    end
  endtask

  task automatic run_op(input string tag, input logic [NB-1:0] av, input logic [NB-1:0] bv,
                        input logic [NB-1:0] ey, input int lat);
    int c0, e0;
    bit got;
    c0 = n_cen;
    e0 = n_err;
    start(av, bv);
    wait_evt(600, got);
    chk({tag, "_seen"}, 32'(got), 32'd1);
    chk({tag, "_done"}, 32'(done_irq_p), 32'd1);
    chk({tag, "_latency"}, 32'(done_cyc - en_cyc), 32'(4 * lat + 5));
    chk({tag, "_y"}, 32'(y), 32'(ey));
    chk({tag, "_core_starts"}, 32'(n_cen - c0), 32'd4);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_no_err"}, 32'(n_err - e0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, e0;
    bit got;

    // Reset state.
    repeat (3) tick();
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pulses", 32'({done_irq_p, err_timeout_p, core_enable_p}), 32'd0);
    chk("rst_core_ops", 32'(core_a | core_b | core_m | core_m_inv), 32'd0);
    rst = 1'b0;
    tick();

    // 5*7 mod 13 = 9, 17-cycle latency, S3 multiplies by 1.
    run_op("op57", 8'd5, 8'd7, 8'd9, 3);
    chk("s3_core_b", 32'(last_core_b), 32'd1);
    chk("core_m", 32'(core_m), 32'd13);
    chk("core_m_inv", 32'(core_m_inv), 32'd59);

    // Back-to-back: second start in the cycle after done.
    run_op("op1212", 8'd12, 8'd12, 8'd1, 3);
    tick();
    run_op("op09", 8'd0, 8'd9, 8'd0, 3);
    tick();

    // Re-pulses during S1 and S2 with different operands are ignored.
    d0 = n_done;
    c0 = n_cen;
    start(8'd5, 8'd7);
    for (int i = 1; i < 40; i++) begin
      if (cyc == en_cyc + 6 || cyc == en_cyc + 10) begin
        a = 8'd1; b = 8'd1; enable_p = 1'b1;
      end else begin
        enable_p = 1'b0;
      end
      tick();
    end
    enable_p = 1'b0;
    chk("repulse_done_cnt", 32'(n_done - d0), 32'd1);
    chk("repulse_y", 32'(y), 32'd9);
    chk("repulse_starts", 32'(n_cen - c0), 32'd4);
    chk("repulse_latency", 32'(done_cyc - en_cyc), 32'd17);

    // Core never answers: timeout after 32 WAIT cycles in S0.
    core_hang = 1'b1;
    d0 = n_done;
    start(8'd3, 8'd4);
    wait_evt(100, got);
    chk("to_seen", 32'(got), 32'd1);
    chk("to_err", 32'(err_timeout_p), 32'd1);
    chk("to_latency", 32'(err_cyc - en_cyc), 32'd34);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_y_held", 32'(y), 32'd9);
    chk("to_no_done", 32'(n_done - d0), 32'd0);
    core_hang = 1'b0;
    repeat (3) tick();

    // Done arriving in the last allowed WAIT cycle completes the step.
    core_lat = 32;
    run_op("lat32", 8'd3, 8'd4, 8'd12, 32);
    tick();

    // One cycle too slow: timeout, y unchanged.
    core_lat = 33;
    d0 = n_done;
    start(8'd2, 8'd2);
    wait_evt(100, got);
    chk("lat33_err", 32'(err_timeout_p), 32'd1);
    chk("lat33_latency", 32'(err_cyc - en_cyc), 32'd34);
    chk("lat33_y_held", 32'(y), 32'd12);
    chk("lat33_no_done", 32'(n_done - d0), 32'd0);
    core_lat = 3;
    repeat (5) tick();

    // Reset in S2 WAIT, then a late core done pulse.
    start(8'd5, 8'd7);
    while (cyc < en_cyc + 10) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_done = 1'b1;
    chk("mrst_y", 32'(y), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_pulses", 32'({done_irq_p, err_timeout_p, core_enable_p}), 32'd0);
    chk("mrst_core_ops", 32'(core_a | core_b | core_m | core_m_inv), 32'd0);
    d0 = n_done;
    e0 = n_err;
    c0 = n_cen;
    tick();
    force_done = 1'b0;
    repeat (20) tick();
    chk("mrst_no_done", 32'(n_done - d0), 32'd0);
    chk("mrst_no_err", 32'(n_err - e0), 32'd0);
    chk("mrst_no_start", 32'(n_cen - c0), 32'd0);
    chk("mrst_idle", 32'(busy), 32'd0);

    // core_done_p while idle, then enable_p together with rst.
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_y", 32'(y), 32'd0);
    c0 = n_cen;
    a = 8'd5; b = 8'd7;
    enable_p = 1'b1;
    rst = 1'b1;
    tick();
    enable_p = 1'b0;
    rst = 1'b0;
    chk("enrst_busy", 32'(busy), 32'd0);
    chk("enrst_core_a", 32'(core_a), 32'd0);
    repeat (5) tick();
    chk("enrst_no_start", 32'(n_cen - c0), 32'd0);
    chk("enrst_idle", 32'(busy), 32'd0);

    chk("never_both", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/montgomery_seq_ctrl.md
MONTGOMERY_SEQ_CTRL -- requirements
Module: montgomery_seq_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NBITS, 2048, operand and modulus width.
- TIMEOUT_CYC, 65535, maximum wait cycles per core operation; 0 disables the timeout.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- enable_p, in, 1, start pulse.
- a, in, NBITS, operand A.
- b, in, NBITS, operand B.
- m, in, NBITS, modulus.
- m_inv, in, NBITS, Montgomery constant.
- r_red, in, NBITS, R^2 mod m.
- y, out, NBITS, result a*b mod m.
- done_irq_p, out, 1, completion pulse.
- err_timeout_p, out, 1, timeout pulse.
- busy, out, 1, sequence in progress.
- core_enable_p, out, 1, start pulse to the shared Montgomery multiplier core.
- core_a, out, NBITS, core operand X.
- core_b, out, NBITS, core operand Y.
- core_m, out, NBITS, core modulus.
- core_m_inv, out, NBITS, core constant.
- core_y, in, NBITS, core result X*Y*R^-1 mod m.
- core_done_p, in, 1, core completion pulse.

Function
REQ-003 The block SHALL sequence one shared multiplier core through four steps, replacing separate to-Montgomery, multiply and from-Montgomery instances:
- S0: core_a=a, core_b=r_red, result AM.
- S1: core_a=b, core_b=r_red, result BM.
- S2: core_a=AM, core_b=BM, result YM.
- S3: core_a=YM, core_b=1, result y.
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, plus a 2-bit step register (0..3).
REQ-005 In IDLE, enable_p=1 SHALL latch a, b, m, m_inv and r_red into internal registers, set step=0 and go to ISSUE; later input changes SHALL NOT affect the operation.
REQ-006 enable_p SHALL be ignored in every state other than IDLE, with no queuing.
REQ-007 ISSUE SHALL last exactly one cycle, drive core_enable_p=1 and go to WAIT. core_a and core_b SHALL already hold the step's operands in that cycle and stay stable through WAIT.
REQ-008 core_m and core_m_inv SHALL be the latched values, constant for the whole sequence.
REQ-009 In WAIT with core_done_p=1, the block SHALL:
- capture core_y into the step's result register;
- if step<3, increment step and go to ISSUE;
- if step=3, load y, pulse done_irq_p for one cycle, and go to IDLE.
REQ-010 core_done_p SHALL be ignored outside WAIT.
REQ-011 With core latency L (core_done_p L cycles after core_enable_p, L>=1), done_irq_p SHALL rise exactly 4L+5 cycles after the enable_p cycle.
REQ-012 busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE; busy SHALL be 0 in the done_irq_p cycle.
REQ-013 A WAIT-cycle counter SHALL clear on WAIT entry. If TIMEOUT_CYC>0 and TIMEOUT_CYC WAIT cycles pass without core_done_p, the block SHALL:
- pulse err_timeout_p for one cycle;
- return to IDLE with no done_irq_p;
- leave y unchanged.
REQ-014 A core_done_p arriving in the last allowed WAIT cycle SHALL complete the step and SHALL NOT raise a timeout.
REQ-015 done_irq_p and err_timeout_p SHALL never be 1 in the same cycle.
REQ-016 y SHALL change only on successful completion of S3 and SHALL hold its value otherwise.

Reset
REQ-017 With rst=1 at a clock edge, the block SHALL:
- go to IDLE and set step=0;
- clear y, all internal result and latch registers, core_a, core_b, core_m, core_m_inv and the timeout counter to 0;
- drive done_irq_p, err_timeout_p, busy and core_enable_p to 0.
REQ-018 rst SHALL take priority over enable_p and core_done_p in the same cycle. Reset in mid-operation SHALL abort the sequence with no done or error pulse, and a late core_done_p after reset SHALL be ignored.

Verification
(Core model for all scenarios: NBITS=8, m=13, R=256, r_red=3, behavioural core with L=3, TIMEOUT_CYC=32.)
REQ-019 a=5, b=7 -> y=9, done_irq_p high exactly 17 cycles after enable_p, exactly 4 core_enable_p pulses, and S3 core_b=1.
REQ-020 a=12, b=12 -> y=1; then a=0, b=9 -> y=0. A second enable_p in the cycle after done_irq_p SHALL be accepted.
REQ-021 enable_p re-pulsed during S1 and S2 with a=1, b=1 -> ignored; a single done_irq_p with y=9 from the original operands.
REQ-022 Core never asserts core_done_p -> err_timeout_p after 32 WAIT cycles in S0, busy=0, y stays at its prior value, and no done_irq_p.
REQ-023 rst asserted during S2 WAIT, core_done_p pulsed 1 cycle later -> all outputs 0 the cycle after reset, state stays IDLE, and no pulses.
REQ-024 core_done_p pulsed while in IDLE, and enable_p plus rst in the same cycle -> no state change, and busy stays 0.
